// File: rtl/sb_pkg.sv
// Shared constants and entry layout for the store buffer.
package sb_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned MASK_W = 4;

  localparam logic [1:0] P_IDLE = 2'd0;
  localparam logic [1:0] P_REQ  = 2'd1;
  localparam logic [1:0] P_WAIT = 2'd2;
  localparam logic [1:0] P_DONE = 2'd3;

  localparam logic [31:0] LED_ADDR = 32'h0000_2000;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic [MASK_W-1:0] mask;
  } sb_entry_t;

endpackage

// File: rtl/sb_fifo.sv
// Circular store queue with a parallel word-address match against a query address.
module sb_fifo
  import sb_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned PTR_W = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                push,
  input  sb_entry_t           push_entry,
  input  logic                pop,
  input  logic [ADDR_W-3:0]   query_word,
  output sb_entry_t           head_entry,
  output logic                full,
  output logic                empty,
  output logic                hit
);

  localparam logic [PTR_W-1:0] PtrOne  = 1;
  localparam logic [PTR_W:0]   CntFull = (PTR_W + 1)'(DEPTH);

  sb_entry_t        mem_q [DEPTH];
  logic [DEPTH-1:0] valid_q;
  logic [PTR_W-1:0] head_q, tail_q;
  logic [PTR_W:0]   count_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      // When full, push and pop share a slot; the push must win the valid bit.
      if (pop) begin
        valid_q[head_q] <= 1'b0;
        head_q          <= head_q + PtrOne;
      end
      if (push) begin
        valid_q[tail_q] <= 1'b1;
        tail_q          <= tail_q + PtrOne;
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[tail_q] <= push_entry;
  end

  assign head_entry = mem_q[head_q];
  assign full       = (count_q == CntFull);
  assign empty      = (count_q == '0);

  always_comb begin
    hit = 1'b0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      if (valid_q[i] && (mem_q[i].addr[ADDR_W-1:2] == query_word)) hit = 1'b1;
    end
  end

endmodule

// File: rtl/store_buffer.sv
// Posted-write buffer in front of data_mem: queues stores, bypasses loads, and
// sequences data_mem's request/wait access so the pipeline only sees a stall.
module store_buffer
  import sb_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned PTR_W = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_write_data,
  input  logic        cpu_memwrite,
  input  logic        cpu_memread,
  input  logic [3:0]  cpu_sign_mask,
  output logic [31:0] cpu_read_data,
  output logic        cpu_stall,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_write_data,
  output logic        mem_memwrite,
  output logic        mem_memread,
  output logic [3:0]  mem_sign_mask,
  input  logic [31:0] mem_read_data,
  output logic        sb_empty
);

  logic [1:0] state_q;
  logic       sel_load_q;
  logic       load_req, store_req, push, pop, full, empty, hit;
  sb_entry_t  head_entry, push_entry;

  assign load_req   = cpu_memread;
  assign store_req  = cpu_memwrite & ~cpu_memread;
  assign pop        = (state_q == P_DONE) & ~sel_load_q;
  // A store into a full queue is taken in the same cycle the head retires.
  assign push       = store_req & (~full | pop);
  assign push_entry = {cpu_addr, cpu_write_data, cpu_sign_mask};

  sb_fifo #(
    .DEPTH(DEPTH),
    .PTR_W(PTR_W)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_entry(push_entry),
    .pop       (pop),
    .query_word(cpu_addr[31:2]),
    .head_entry(head_entry),
    .full      (full),
    .empty     (empty),
    .hit       (hit)
  );

  always_comb begin
    cpu_stall = 1'b0;
    if (load_req) begin
      cpu_stall = ~((state_q == P_DONE) & sel_load_q);
    end else if (store_req) begin
      cpu_stall = full & ~pop;
    end
  end

  assign sb_empty = empty & (state_q == P_IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= P_IDLE;
      sel_load_q     <= 1'b0;
      mem_memread    <= 1'b0;
      mem_memwrite   <= 1'b0;
      mem_addr       <= '0;
      mem_write_data <= '0;
      mem_sign_mask  <= '0;
      cpu_read_data  <= '0;
    end else begin
      case (state_q)
        P_IDLE: begin
          if (load_req && !hit) begin
            state_q        <= P_REQ;
            sel_load_q     <= 1'b1;
            mem_memread    <= 1'b1;
            mem_addr       <= cpu_addr;
            mem_write_data <= cpu_write_data;
            mem_sign_mask  <= cpu_sign_mask;
          end else if (!empty) begin
            state_q        <= P_REQ;
            sel_load_q     <= 1'b0;
            mem_memwrite   <= 1'b1;
            mem_addr       <= head_entry.addr;
            mem_write_data <= head_entry.data;
            mem_sign_mask  <= head_entry.mask;
          end
        end
        P_REQ: begin
          mem_memread  <= 1'b0;
          mem_memwrite <= 1'b0;
          state_q      <= P_WAIT;
        end
        P_WAIT: begin
          // Captured here so the data is on cpu_read_data throughout P_DONE.
          if (sel_load_q) cpu_read_data <= mem_read_data;
          state_q <= P_DONE;
        end
        default: state_q <= P_IDLE;
      endcase
    end
  end

endmodule
